// File: rtl/trng_stream_rx.sv
// Purpose: capture the tinytrng serial stream (bclk/random pins), deserialize MSB-first, health-check, buffer bytes.
// Latency: pin bclk rise to sample event 2-3 clk; a completed byte is visible at the FIFO head one cycle later.
// Backpressure: valid/ready consumer; bytes arriving while the FIFO is full (and not popping) are dropped, setting overflow.
module trng_stream_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          random,
    input  logic                          bclk,
    output logic [7:0]                    data,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          health_fail,
    input  logic                          clear
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0]    REP_MAX = 8'(REP_LIMIT);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    // pin synchronizers and edge detect
    logic       bclk_s1, bclk_s2, bclk_prev;
    logic       rnd_s1, rnd_s2;
    logic [1:0] settle;

    // deserializer
    logic [2:0] bitcnt;
    logic [6:0] shreg;

    // repetition-count health test
    logic [7:0] run;
    logic [7:0] run_next;
    logic       run_hist;
    logic       last_bit;

    // byte FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    logic       sample;
    logic       byte_done;
    logic [7:0] byte_new;
    logic       hf_set;
    logic       full;
    logic       pop;
    logic       push;
    logic       ovf_set;

    // Two-flop synchronizers. bclk_prev is held high until the synchronizer has
    // filled with the real pin value, so a bclk already high at reset release
    // never looks like a rising edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bclk_s1   <= 1'b0;
            bclk_s2   <= 1'b0;
            rnd_s1    <= 1'b0;
            rnd_s2    <= 1'b0;
            bclk_prev <= 1'b1;
            settle    <= 2'd0;
        end else begin
            bclk_s1   <= bclk;
            bclk_s2   <= bclk_s1;
            rnd_s1    <= random;
            rnd_s2    <= rnd_s1;
            bclk_prev <= (settle == 2'd2) ? bclk_s2 : 1'b1;
            if (settle != 2'd2)
                settle <= settle + 2'd1;
        end
    end

    // Sample event, byte completion and run-length bookkeeping for this cycle
    always_comb begin
        sample    = bclk_s2 & ~bclk_prev;
        byte_done = sample && (bitcnt == 3'd7);
        byte_new  = {shreg, rnd_s2};
        run_next  = 8'd1;
        if (run_hist && (rnd_s2 == last_bit))
            run_next = (run == REP_MAX) ? run : run + 8'd1;
        hf_set    = sample && (run_next == REP_MAX);
        full      = (level == LVL_FULL);
        pop       = valid && ready;
        push      = byte_done && !health_fail && !hf_set && (!full || pop);
        ovf_set   = byte_done && !health_fail && !hf_set && full && !pop;
    end

    // Shift register and bit counter keep byte alignment regardless of health state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bitcnt <= 3'd0;
            shreg  <= 7'd0;
        end else if (sample) begin
            bitcnt <= bitcnt + 3'd1;
            shreg  <= byte_new[6:0];
        end
    end

    // Run counter; clear forgets history so the next bit starts a fresh run
    always_ff @(posedge clk) begin
        if (!resetn) begin
            run      <= 8'd0;
            run_hist <= 1'b0;
            last_bit <= 1'b0;
        end else if (clear) begin
            run      <= 8'd0;
            run_hist <= 1'b0;
        end else if (sample) begin
            run      <= run_next;
            run_hist <= 1'b1;
            last_bit <= rnd_s2;
        end
    end

    // Sticky flags; a set in the same cycle as clear wins
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow    <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            overflow    <= ovf_set | (overflow & ~clear);
            health_fail <= hf_set | (health_fail & ~clear);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= byte_new;
    end

    // First-word-fall-through head
    always_comb begin
        valid = (level != '0);
        data  = mem[rd_ptr];
    end

endmodule

// File: tb/tb_trng_stream_rx.sv
module tb_trng_stream_rx;

    logic       clk;
    logic       resetn;
    logic       random;
    logic       bclk;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [2:0] level;
    logic       overflow;
    logic       health_fail;
    logic       clear;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    trng_stream_rx #(.FIFO_DEPTH(4), .REP_LIMIT(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .random      (random),
        .bclk        (bclk),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .level       (level),
        .overflow    (overflow),
        .health_fail (health_fail),
        .clear       (clear)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted head byte must match the oldest expected byte
    always @(negedge clk) begin
        if (resetn && valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got %0h expected none", data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", data, e);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        random = b;
        bclk   = 1'b0;
        tick(8);
        bclk   = 1'b1;
        tick(8);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            send_bit(v[i]);
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++)
            send_bit(1'b1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(4);
    endtask

    task automatic drain(input string name);
        int cnt;
        cnt   = 0;
        ready = 1'b1;
        while (valid && cnt < 50) begin
            tick(1);
            cnt++;
        end
        ready = 1'b0;
        check({name, "_timeout"}, (cnt >= 50) ? 32'd1 : 32'd0, 32'd0);
        check({name, "_queue_left"}, exp_q.size(), 0);
        check({name, "_level"}, level, 0);
    endtask

    initial begin
        logic [7:0] v;
        clk    = 1'b0;
        resetn = 1'b0;
        bclk   = 1'b1;
        random = 1'b0;
        ready  = 1'b0;
        clear  = 1'b0;
        tick(3);
        check("rst_valid", valid, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_health", health_fail, 0);

        // bclk high across reset release: no sample
        resetn = 1'b1;
        tick(10);
        check("no_sample_level", level, 0);

        // 0xA5: first seven bits, then time the eighth rise
        v = 8'hA5;
        for (int i = 7; i >= 1; i--)
            send_bit(v[i]);
        random = 1'b1;
        bclk   = 1'b0;
        tick(8);
        bclk   = 1'b1;
        tick(4);
        check("a5_valid", valid, 1);
        check("a5_data", data, 8'hA5);
        tick(4);
        exp_q.push_back(8'hA5);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("a5_valid_after_pop", valid, 0);
        check("a5_level_after_pop", level, 0);

        // Overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) begin
            v = 8'(i);
            send_byte(v);
            if (i <= 4)
                exp_q.push_back(v);
        end
        check("ovf_level", level, 4);
        check("ovf_flag", overflow, 1);
        drain("ovf_drain");
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO: push and pop in the same cycle
        for (int i = 1; i <= 4; i++) begin
            v = 8'(i);
            send_byte(v);
            exp_q.push_back(v);
        end
        check("full_level", level, 4);
        v = 8'h05;
        for (int i = 7; i >= 1; i--)
            send_bit(v[i]);
        random = 1'b1;
        bclk   = 1'b0;
        tick(8);
        bclk   = 1'b1;
        tick(2);
        ready  = 1'b1;
        tick(1);
        ready  = 1'b0;
        exp_q.push_back(8'h05);
        tick(5);
        check("pp_overflow", overflow, 0);
        check("pp_level", level, 4);
        drain("pp_drain");

        // Health: 31 ones then a zero does not trip
        do_reset();
        ready = 1'b1;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
        send_ones(31);
        send_bit(1'b0);
        ready = 1'b0;
        check("h31_health", health_fail, 0);
        check("h31_queue", exp_q.size(), 0);

        // Health: 32 ones trips on the 32nd bit, fourth byte discarded
        do_reset();
        send_ones(31);
        check("h32_before", health_fail, 0);
        send_bit(1'b1);
        check("h32_health", health_fail, 1);
        check("h32_level", level, 3);
        check("h32_overflow", overflow, 0);
        send_byte(8'h00);
        check("h32_discard_level", level, 3);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        drain("h32_drain");

        // Clear with both flags set and two bytes queued
        do_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h54);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_ones(32);
        check("clr_pre_overflow", overflow, 1);
        check("clr_pre_health", health_fail, 1);
        ready = 1'b1;
        tick(2);
        ready = 1'b0;
        check("clr_pre_level", level, 2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_health", health_fail, 0);
        check("clr_level", level, 2);
        send_byte(8'h3C);
        check("clr_accept_level", level, 3);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h3C);
        drain("clr_drain");

        // Reset mid-byte discards partial bits
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        do_reset();
        send_byte(8'h5A);
        check("mid_level", level, 1);
        check("mid_data", data, 8'h5A);
        check("mid_overflow", overflow, 0);
        check("mid_health", health_fail, 0);
        exp_q.push_back(8'h5A);
        drain("mid_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
